// File: rtl/gigatron_pkg.sv
// Shared constants for the gigatron video back-end: OUT register bit fields,
// lock FSM states and the accepted frame-length window.
package gigatron_pkg;
  localparam int R_LSB  = 0;
  localparam int G_LSB  = 2;
  localparam int B_LSB  = 4;
  localparam int HS_BIT = 6;
  localparam int VS_BIT = 7;

  // Lines per frame, counted as hsync falls since the last vsync fall
  localparam int FRAME_MIN = 500;
  localparam int FRAME_MAX = 530;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_e;
endpackage

// File: rtl/gigatron_video_lock.sv
// Lock / loss-of-signal monitor: frame-length qualification and an hsync
// watchdog counted in ce pulses.
module gigatron_video_lock
  import gigatron_pkg::*;
#(
  parameter int Y_W         = 10,
  parameter int TIMEOUT     = 2048,
  parameter int LOCK_FRAMES = 2
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           hs_fall,
  input  logic           vs_fall,
  input  logic [Y_W-1:0] pos_y,
  output logic           locked,
  output lock_state_e    state
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [TW-1:0]  T_MAX  = TW'(TIMEOUT);
  localparam logic [GW-1:0]  G_LAST = GW'(LOCK_FRAMES - 1);
  localparam logic [Y_W-1:0] Y_MIN  = Y_W'(FRAME_MIN);
  localparam logic [Y_W-1:0] Y_MAX  = Y_W'(FRAME_MAX);

  logic [TW-1:0] tcnt, tcnt_nxt;
  logic [GW-1:0] good;
  logic          in_win, tmo;

  // Watchdog saturates so it keeps holding SEARCH until an hsync fall returns
  always_comb begin
    tcnt_nxt = tcnt;
    if (hs_fall)             tcnt_nxt = '0;
    else if (tcnt != T_MAX)  tcnt_nxt = tcnt + 1'b1;
  end

  assign tmo    = (tcnt_nxt == T_MAX);
  assign in_win = (pos_y >= Y_MIN) && (pos_y <= Y_MAX);

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state  <= ST_SEARCH;
      tcnt   <= '0;
      good   <= '0;
      locked <= 1'b0;
    end else if (ce) begin
      tcnt <= tcnt_nxt;
      if (tmo) begin
        state  <= ST_SEARCH;
        locked <= 1'b0;
        good   <= '0;
      end else if (vs_fall) begin
        case (state)
          ST_SEARCH: begin
            state <= ST_ACQUIRE;
            good  <= '0;
          end
          ST_ACQUIRE: begin
            if (!in_win) begin
              good <= '0;
            end else if (good == G_LAST) begin
              state  <= ST_LOCKED;
              locked <= 1'b1;
              good   <= '0;
            end else begin
              good <= good + 1'b1;
            end
          end
          ST_LOCKED: begin
            if (!in_win) begin
              state  <= ST_SEARCH;
              locked <= 1'b0;
            end
          end
          default: begin
            state  <= ST_SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/gigatron_video_out.sv
// Gigatron OUT register to VGA pins: ce-qualified capture, colour expansion,
// beam counters and lock monitor. Optional stats: GIGATRON_VIDEO_STATS_EN.
module gigatron_video_out
  import gigatron_pkg::*;
#(
  parameter int COLOR_W     = 4,
  parameter int X_W         = 9,
  parameter int Y_W         = 10,
  parameter int TIMEOUT     = 2048,
  parameter int LOCK_FRAMES = 2
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               ce,
  input  logic [7:0]         out_i,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic [X_W-1:0]     pos_x,
  output logic [Y_W-1:0]     pos_y,
  output logic               frame_tick,
  output logic               locked
`ifdef GIGATRON_VIDEO_STATS_EN
  ,
  output logic [X_W-1:0]     line_len,
  output logic [Y_W-1:0]     frame_lines,
  output logic [15:0]        frame_cnt
`endif
);
  // prev_out doubles as the capture register; its reset value has both
  // syncs high so the first sample after reset cannot fake an edge
  logic [7:0]         prev_out;
  logic               hs_fall, vs_fall, show;
  logic [COLOR_W-1:0] r_exp, g_exp, b_exp;
  lock_state_e        lock_state;

  assign hs_fall = prev_out[HS_BIT] & ~out_i[HS_BIT];
  assign vs_fall = prev_out[VS_BIT] & ~out_i[VS_BIT];

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      prev_out   <= 8'hC0;
      pos_x      <= '0;
      pos_y      <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= ce & vs_fall;
      if (ce) begin
        prev_out <= out_i;
        if (hs_fall)     pos_x <= '0;
        else if (~&pos_x) pos_x <= pos_x + 1'b1;
        if (vs_fall)                pos_y <= '0;
        else if (hs_fall && ~&pos_y) pos_y <= pos_y + 1'b1;
      end
    end
  end

`ifdef GIGATRON_VIDEO_STATS_EN
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      line_len    <= '0;
      frame_lines <= '0;
      frame_cnt   <= '0;
    end else if (ce) begin
      if (hs_fall) line_len <= pos_x;
      if (vs_fall) begin
        frame_lines <= pos_y;
        frame_cnt   <= frame_cnt + 1'b1;
      end
    end
  end
`endif

  // MSB-first replication of the 2-bit channel: c1 c0 c1 c0 ...
  for (genvar i = 0; i < COLOR_W; i++) begin : g_exp_bit
    localparam int SB = 1 - (i % 2);
    assign r_exp[COLOR_W-1-i] = prev_out[R_LSB + SB];
    assign g_exp[COLOR_W-1-i] = prev_out[G_LSB + SB];
    assign b_exp[COLOR_W-1-i] = prev_out[B_LSB + SB];
  end

  assign show   = (lock_state == ST_LOCKED);
  assign vga_r  = show ? r_exp : '0;
  assign vga_g  = show ? g_exp : '0;
  assign vga_b  = show ? b_exp : '0;
  assign vga_hs = prev_out[HS_BIT];
  assign vga_vs = prev_out[VS_BIT];

  gigatron_video_lock #(
    .Y_W         (Y_W),
    .TIMEOUT     (TIMEOUT),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_lock (
    .clock   (clock),
    .rst_n   (rst_n),
    .ce      (ce),
    .hs_fall (hs_fall),
    .vs_fall (vs_fall),
    .pos_y   (pos_y),
    .locked  (locked),
    .state   (lock_state)
  );
endmodule

// File: tb/tb_gigatron_video_out.sv
// Bench for gigatron_video_out: frame-level reference model compared every
// cycle, plus directed literal checks.
module tb_gigatron_video_out;
  localparam int COLOR_W = 4;
  localparam int X_W = 9;
  localparam int Y_W = 10;
  localparam int TIMEOUT = 2048;
  localparam int LOCK_FRAMES = 2;
  localparam int LINE = 12;

  logic clock = 1'b0;
  logic rst_n, ce;
  logic [7:0] out_i;
  logic [COLOR_W-1:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, frame_tick, locked;
  logic [X_W-1:0] pos_x;
  logic [Y_W-1:0] pos_y;
`ifdef GIGATRON_VIDEO_STATS_EN
  logic [X_W-1:0] line_len;
  logic [Y_W-1:0] frame_lines;
  logic [15:0] frame_cnt;
`endif

  gigatron_video_out #(
    .COLOR_W(COLOR_W), .X_W(X_W), .Y_W(Y_W), .TIMEOUT(TIMEOUT), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clock(clock), .rst_n(rst_n), .ce(ce), .out_i(out_i),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .pos_x(pos_x), .pos_y(pos_y), .frame_tick(frame_tick), .locked(locked)
`ifdef GIGATRON_VIDEO_STATS_EN
    , .line_len(line_len), .frame_lines(frame_lines), .frame_cnt(frame_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0, n_ticks = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [COLOR_W-1:0] expand(input logic [1:0] c);
    logic [7:0] t;
    t = {4{c}};
    return t[7 -: COLOR_W];
  endfunction

  // Reference model: the state of the video stream as described in words
  logic [7:0] m_prev;
  int m_x, m_y, m_since, m_good, m_lines, m_len, m_frames;
  bit m_tick, m_lock, m_seen;

  always @(posedge clock) begin
    started = 1'b1;
    if (!rst_n) begin
      m_prev = 8'hC0; m_x = 0; m_y = 0; m_tick = 0; m_lock = 0; m_seen = 0;
      m_good = 0; m_since = 0; m_lines = 0; m_len = 0; m_frames = 0;
    end else begin
      m_tick = 0;
      if (ce) begin
        bit hf, vf, ok;
        hf = m_prev[6] && !out_i[6];
        vf = m_prev[7] && !out_i[7];
        ok = (m_y >= 500) && (m_y <= 530);
        if (hf) m_len = m_x;
        if (vf) begin m_lines = m_y; m_frames = (m_frames + 1) % 65536; end
        if (hf) m_since = 0; else if (m_since < TIMEOUT) m_since++;
        if (m_since == TIMEOUT) begin
          m_lock = 0; m_seen = 0; m_good = 0;
        end else if (vf) begin
          if (m_lock) begin
            if (!ok) begin m_lock = 0; m_seen = 0; end
          end else if (m_seen) begin
            if (ok) begin
              m_good++;
              if (m_good == LOCK_FRAMES) begin m_lock = 1; m_good = 0; end
            end else m_good = 0;
          end else begin
            m_seen = 1; m_good = 0;
          end
        end
        if (hf) m_x = 0; else if (m_x < (1 << X_W) - 1) m_x++;
        if (vf) m_y = 0; else if (hf && m_y < (1 << Y_W) - 1) m_y++;
        m_tick = vf;
        m_prev = out_i;
      end
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("vga_r", 32'(vga_r), 32'(m_lock ? expand(m_prev[1:0]) : '0));
      chk("vga_g", 32'(vga_g), 32'(m_lock ? expand(m_prev[3:2]) : '0));
      chk("vga_b", 32'(vga_b), 32'(m_lock ? expand(m_prev[5:4]) : '0));
      chk("vga_hs", 32'(vga_hs), 32'(m_prev[6]));
      chk("vga_vs", 32'(vga_vs), 32'(m_prev[7]));
      chk("pos_x", 32'(pos_x), m_x);
      chk("pos_y", 32'(pos_y), m_y);
      chk("frame_tick", 32'(frame_tick), 32'(m_tick));
      chk("locked", 32'(locked), 32'(m_lock));
`ifdef GIGATRON_VIDEO_STATS_EN
      chk("line_len", 32'(line_len), m_len);
      chk("frame_lines", 32'(frame_lines), m_lines);
      chk("frame_cnt", 32'(frame_cnt), m_frames);
`endif
      if (frame_tick) n_ticks++;
    end
  end

  task automatic tick(input logic c, input logic [7:0] o);
    ce = c; out_i = o;
    @(posedge clock); #1;
  endtask

  task automatic run_frame(input int n);
    for (int l = 0; l < n; l++)
      for (int c = 0; c < LINE; c++)
        tick(1'b1, {l >= 2, c >= 2, 6'((l + c) & 63)});
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; out_i = 8'h3F;
    for (int i = 0; i < 3; i++) begin
      tick(~ce, 8'h3F);
      chk("rst_r", 32'(vga_r), 0);
      chk("rst_hs", 32'(vga_hs), 1);
      chk("rst_vs", 32'(vga_vs), 1);
      chk("rst_pos", 32'({pos_x, pos_y}), 0);
      chk("rst_locked", 32'(locked), 0);
    end
    rst_n = 1'b1;
    tick(1'b0, 8'hC0);

    // 200-ce lines, hsync low for 12, ce on every other clock
    for (int l = 0; l < 3; l++)
      for (int c = 0; c < 200; c++) begin
        tick(1'b1, {1'b1, c >= 12, 6'(c & 63)});
        if (l == 0 && c == 0) begin
          chk("x_on_fall", 32'(pos_x), 0);
          chk("y_first", 32'(pos_y), 1);
        end
        if (c == 199) chk("x_end", 32'(pos_x), 199);
        tick(1'b0, {1'b1, c >= 12, 6'(c & 63)});
      end
    chk("y_three", 32'(pos_y), 3);

    n_ticks = 0;
    run_frame(521);
    run_frame(521);
    chk("lock_not_yet", 32'(locked), 0);
    run_frame(521);
    chk("lock_rise", 32'(locked), 1);
    chk("tick_count", n_ticks, 3);
`ifdef GIGATRON_VIDEO_STATS_EN
    chk("stat_line_len", 32'(line_len), LINE - 1);
    chk("stat_frame_lines", 32'(frame_lines), 520);
    chk("stat_frame_cnt", 32'(frame_cnt), 3);
`endif

    tick(1'b1, 8'hE6);
    for (int i = 0; i < 3; i++) begin
      chk("e6_r", 32'(vga_r), 32'h0A);
      chk("e6_g", 32'(vga_g), 32'h05);
      chk("e6_b", 32'(vga_b), 32'h0A);
      chk("e6_syncs", 32'({vga_hs, vga_vs}), 32'h3);
      tick(1'b0, 8'h00);
    end

    tick(1'b1, 8'hBF);
    for (int i = 0; i < TIMEOUT - 1; i++) tick(1'b1, 8'hFF);
    chk("tmo_hold_lock", 32'(locked), 1);
    chk("tmo_hold_r", 32'(vga_r), 32'h0F);
    tick(1'b1, 8'hFF);
    chk("tmo_drop_lock", 32'(locked), 0);
    chk("tmo_drop_r", 32'(vga_r), 0);

    run_frame(521);
    run_frame(521);
    run_frame(521);
    chk("relock", 32'(locked), 1);
    run_frame(400);
    tick(1'b1, 8'h3F);
    chk("short_frame_drop", 32'(locked), 0);
    chk("short_frame_y", 32'(pos_y), 0);

    rst_n = 1'b0;
    tick(1'b1, 8'h15);
    chk("midrst_x", 32'(pos_x), 0);
    chk("midrst_hs", 32'(vga_hs), 1);
    chk("midrst_lock", 32'(locked), 0);
    rst_n = 1'b1;
    tick(1'b1, 8'hC0);
    chk("midrst_no_edge_y", 32'(pos_y), 0);
    chk("midrst_no_edge_x", 32'(pos_x), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
